// File: rtl/msr_pkg.sv
// Shared types for the multi-mode shift register sequencer: register modes,
// command opcodes and sequencer states.
package msr_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_SHR  = 2'b01,
      OP_SHL  = 2'b10,
      OP_LOAD = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_SHIFT = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

endpackage

// File: rtl/msr_core.sv
// Universal shift register: hold, shift right, shift left or parallel load,
// with synchronous active-high clear.
module msr_core
   import msr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  mode_e            mode,
   input  logic [WIDTH-1:0] pin,
   input  logic             sin,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else begin
         case (mode)
            MODE_SHR:  q <= {sin, q[WIDTH-1:1]};
            MODE_SHL:  q <= {q[WIDTH-2:0], sin};
            MODE_LOAD: q <= pin;
            default:   q <= q;
         endcase
      end
   end

endmodule

// File: rtl/msr_sequencer.sv
// Command sequencer driving an internal msr_core: one command per handshake,
// counted shifts, one-cycle done pulse. Optional rotate via MSR_SEQ_ROTATE_EN.
module msr_sequencer
   import msr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             cmd_rot,
   input  logic             ser_in,
   output logic [1:0]       mode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q
);

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_clamp;
   logic [WIDTH-1:0] data_q;
   logic             accept;
   logic             sin;

   assign cmd_ready = (state_q == ST_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign mode      = mode_q;
   assign cnt_clamp = (cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_count;

   // mode is computed for the next state so it leaves a register alongside state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = MODE_HOLD;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (op_e'(cmd_op))
                  OP_LOAD: begin
                     state_d = ST_LOAD;
                     mode_d  = MODE_LOAD;
                  end
                  OP_SHR, OP_SHL: begin
                     if (cnt_clamp != '0) begin
                        state_d = ST_SHIFT;
                        cnt_d   = cnt_clamp;
                        mode_d  = (op_e'(cmd_op) == OP_SHR) ? MODE_SHR : MODE_SHL;
                     end else begin
                        state_d = ST_DONE;
                     end
                  end
                  default: state_d = ST_DONE;
               endcase
            end
         end
         ST_LOAD: state_d = ST_DONE;
         ST_SHIFT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end else begin
               mode_d = mode_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         mode_q  <= MODE_HOLD;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         data_q <= cmd_data;
      end
   end

`ifdef MSR_SEQ_ROTATE_EN
   logic rot_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rot_q <= 1'b0;
      end else if (accept) begin
         rot_q <= cmd_rot;
      end
   end

   // rotation feeds back the bit leaving the register in the current direction
   assign sin = rot_q ? ((mode_q == MODE_SHR) ? q[0] : q[WIDTH-1]) : ser_in;
`else
   logic unused_rot;

   assign unused_rot = cmd_rot;
   assign sin        = ser_in;
`endif

   msr_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk (clk),
      .rst (rst),
      .mode(mode_q),
      .pin (data_q),
      .sin (sin),
      .q   (q)
   );

endmodule
